param_add_accum: RTL and testbench
==================================

// Module: param_add_accum
// PURPOSE
//  Parametrised registered adder/subtractor with a running accumulator and valid/ready handshakes.
//  Successor to the fixed 4-bit nibble adder: generic operand width, selectable mode, carry/borrow flag,
//  optional saturation, and back-pressure. Sits between the pad-level input decode and the output mux.
// PARAMETERS
//  WIDTH     4  operand width (op_a, op_b), >=2
//  ACC_EXT   4  extra result/accumulator bits; RW = WIDTH+ACC_EXT
//  SATURATE  0  0: wrap modulo 2^RW; 1: clamp (SUB underflow -> 0, ACC overflow -> 2^RW-1)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  op_a       in   WIDTH    operand A, unsigned
//  op_b       in   WIDTH    operand B, unsigned
//  mode       in   2        00 ADD, 01 SUB, 10 ACC, 11 CLR
//  out_valid  out  1        result beat valid
//  out_ready  in   1        consumer accepts result this cycle
//  result     out  RW       result value
//  flag       out  1        ADD: carry out of RW; SUB: borrow (a<b); ACC: overflow of RW; CLR: 0
//  acc_cnt    out  8        ACC beats since last CLR/reset, saturates at 255
// BEHAVIOUR
//  - Reset (1 cycle, synchronous): out_valid=0, result=0, flag=0, acc=0, acc_cnt=0; in_ready=0 while reset high.
//  - in_ready = !out_valid || out_ready (combinational, single output register, no skid buffer).
//  - Beat accepted on edge where in_valid && in_ready; result/flag/out_valid update on that same edge (latency 1).
//  - out_valid falls when out_valid && out_ready && no new accept; result/flag held stable while out_valid && !out_ready.
//  - Full throughput: one beat per cycle when out_ready=1 continuously.
//  - Operands zero-extended to RW bits before arithmetic; one extra internal bit for carry/borrow detection.
//  - ADD: result = a+b (cannot overflow for ACC_EXT>=1; flag=0 then). acc untouched.
//  - SUB: result = a-b mod 2^RW, flag = (a<b); SATURATE=1 -> result 0 on borrow. acc untouched.
//  - ACC: acc_next = acc + a + b; flag = carry out of RW; SATURATE=1 -> acc_next = 2^RW-1 on carry;
//         acc <= acc_next, result = acc_next, acc_cnt += 1 (stops at 255).
//  - CLR: acc <= 0, acc_cnt <= 0, result = 0, flag = 0; still produces an output beat.
//  - acc/acc_cnt change only on accepted ACC/CLR beats; unaccepted inputs have no effect.
//  - Inputs sampled only on accept; op_a/op_b/mode may change freely otherwise.
//  - reset during a stalled beat: pending result discarded, out_valid=0 next cycle, acc cleared.
//  - reset and in_valid same cycle: reset wins, beat dropped.
// STRUCTURE
//  - Package add_accum_pkg: MODE_ADD/SUB/ACC/CLR localparams (2-bit), mode typedef.
//  - Sub-module sat_add: combinational RW-bit add/sub with carry/borrow out and SATURATE clamp;
//    instantiated once, shared by ADD/SUB/ACC via operand mux (ACC: lhs=acc, rhs=a+b).
//  - Top: handshake control, output register, acc and acc_cnt registers.
// TESTING (WIDTH=4, ACC_EXT=4, RW=8 unless stated)
//  1. Reset 2 cycles, then ADD a=9 b=8, out_ready=1 -> next cycle out_valid=1, result=0x11, flag=0.
//  2. SUB a=3 b=5 -> result=0xFE flag=1; rerun SATURATE=1 -> result=0x00 flag=1.
//  3. 9 ACC beats a=15 b=15 -> 8th result=240 flag=0; 9th result=14 flag=1 (SATURATE=1: 255),
//     acc_cnt=9; then CLR -> result=0, acc_cnt=0.
//  4. ADD beat with out_ready=0 for 3 cycles -> result/flag stable, in_ready=0, second offered beat
//     not taken; out_ready=1 -> second beat accepted that edge, appears next cycle.
//  5. Stream 16 random ADD/SUB beats, in_valid=out_ready=1 -> 16 results in 16 consecutive cycles,
//     all match model.
//  6. reset asserted while stalled after ACC (acc=30) -> next cycle out_valid=0, acc_cnt=0;
//     subsequent ACC a=1 b=1 -> result=2.

Source files
------------

// File: rtl/add_accum_pkg.sv
// Shared mode encoding for the add/accumulate datapath.
// Imported by param_add_accum.
package add_accum_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD = 2'b00;
  localparam mode_t MODE_SUB = 2'b01;
  localparam mode_t MODE_ACC = 2'b10;
  localparam mode_t MODE_CLR = 2'b11;

endpackage

// File: rtl/sat_add.sv
// Combinational RW-bit add/sub with carry/borrow out and optional clamp.
// Ports: lhs_i, rhs_i operands; sub_i selects lhs-rhs; res_o, cy_o.
module sat_add #(
  parameter int RW       = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [RW-1:0] lhs_i,
  input  logic [RW-1:0] rhs_i,
  input  logic          sub_i,
  output logic [RW-1:0] res_o,
  output logic          cy_o
);

  logic [RW:0] raw;

  always_comb begin
    if (sub_i) raw = {1'b0, lhs_i} - {1'b0, rhs_i};
    else       raw = {1'b0, lhs_i} + {1'b0, rhs_i};
    cy_o  = raw[RW];
    res_o = raw[RW-1:0];
    // borrow clamps to 0, carry clamps to all ones
    if (SATURATE && raw[RW]) res_o = sub_i ? '0 : '1;
  end

endmodule

// File: rtl/param_add_accum.sv
// Registered add/sub/accumulate unit with valid/ready handshakes.
// Ports: clk, reset, in_*/op_a/op_b/mode in, out_*/result/flag/acc_cnt out.
module param_add_accum
  import add_accum_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int ACC_EXT  = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+ACC_EXT-1:0] result,
  output logic                     flag,
  output logic [7:0]               acc_cnt
);

  localparam int RW = WIDTH + ACC_EXT;

  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] result_q, result_d;
  logic          flag_q, flag_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [RW-1:0] a_ext, b_ext;
  logic [RW-1:0] lhs, rhs, sum;
  logic          sub, cy, accept;
  mode_t         md;

  assign md     = mode;
  assign a_ext  = RW'(op_a);
  assign b_ext  = RW'(op_b);
  // single output register: a beat may enter only as the old one leaves
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // one shared adder; ACC folds a+b into the rhs operand
  always_comb begin
    lhs = a_ext;
    rhs = b_ext;
    sub = 1'b0;
    unique case (md)
      MODE_SUB: sub = 1'b1;
      MODE_ACC: begin
        lhs = acc_q;
        rhs = a_ext + b_ext;
      end
      default: ;
    endcase
  end

  sat_add #(
    .RW       (RW),
    .SATURATE (SATURATE)
  ) u_alu (
    .lhs_i (lhs),
    .rhs_i (rhs),
    .sub_i (sub),
    .res_o (sum),
    .cy_o  (cy)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_d      = flag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = sum;
      flag_d      = cy;
      unique case (md)
        MODE_ACC: begin
          acc_d = sum;
          cnt_d = cnt_q + 8'(cnt_q != 8'hFF);
        end
        MODE_CLR: begin
          result_d = '0;
          flag_d   = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
        end
        default: ;
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag      = flag_q;
  assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_param_add_accum.sv
// Testbench for param_add_accum: wrap and saturating instances side by side.
// Directed table, corner sequences and a queue scoreboard.
module tb_param_add_accum;

  logic       clk, reset;
  logic       in_valid, in_ready, in_ready_s;
  logic [3:0] op_a, op_b;
  logic [1:0] mode;
  logic       out_valid, out_valid_s, out_ready;
  logic [7:0] result, result_s, acc_cnt, acc_cnt_s;
  logic       flag, flag_s;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  param_add_accum #(.WIDTH(4), .ACC_EXT(4), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag(flag), .acc_cnt(acc_cnt)
  );

  param_add_accum #(.WIDTH(4), .ACC_EXT(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid_s),
    .out_ready(out_ready), .result(result_s), .flag(flag_s),
    .acc_cnt(acc_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] r;
    logic       f;
    logic [7:0] rs;
    logic       fs;
  } exp_t;

  exp_t sbq[$];
  int   m_acc = 0, m_acc_s = 0, m_cnt = 0;

  always @(negedge clk) begin : sb
    exp_t e;
    int   a, b, s, s2;
    chk("sb_valid", 32'(out_valid), 32'(sbq.size() != 0));
    chk("sb_valid_s", 32'(out_valid_s), 32'(out_valid));
    if (out_valid === 1'b1 && sbq.size() != 0) begin
      e = sbq[0];
      chk("sb_result", 32'(result), 32'(e.r));
      chk("sb_flag", 32'(flag), 32'(e.f));
      chk("sb_result_s", 32'(result_s), 32'(e.rs));
      chk("sb_flag_s", 32'(flag_s), 32'(e.fs));
      if (out_ready === 1'b1) begin
        void'(sbq.pop_front());
        pops++;
      end
    end
    chk("sb_acc_cnt", 32'(acc_cnt), 32'(m_cnt));
    chk("sb_acc_cnt_s", 32'(acc_cnt_s), 32'(m_cnt));
    if (reset === 1'b1) begin
      sbq.delete();
      m_acc = 0;
      m_acc_s = 0;
      m_cnt = 0;
    end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
      a = int'(op_a);
      b = int'(op_b);
      case (mode)
        2'b00: begin
          s = a + b;
          e.r = 8'(s); e.f = (s > 255);
          e.rs = e.r; e.fs = e.f;
        end
        2'b01: begin
          e.f = (a < b); e.r = 8'(a - b + 256);
          e.rs = (a < b) ? 8'd0 : e.r; e.fs = e.f;
        end
        2'b10: begin
          s = m_acc + a + b;
          e.f = (s > 255); e.r = 8'(s);
          m_acc = int'(e.r);
          s2 = m_acc_s + a + b;
          e.fs = (s2 > 255); e.rs = (s2 > 255) ? 8'd255 : 8'(s2);
          m_acc_s = int'(e.rs);
          if (m_cnt < 255) m_cnt++;
        end
        default: begin
          e.r = 8'd0; e.f = 1'b0; e.rs = 8'd0; e.fs = 1'b0;
          m_acc = 0; m_acc_s = 0; m_cnt = 0;
        end
      endcase
      sbq.push_back(e);
    end
  end

  // called just after a posedge; returns just after the accepting posedge
  task automatic send(input logic [1:0] m, input int a, input int b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; mode = m; op_a = 4'(a); op_b = 4'(b);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no in_ready expected in_ready=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] m;
    int         a, b;
    logic [7:0] r;
    logic       f;
    logic [7:0] rs;
    logic       fs;
  } vec_t;

  vec_t vt[8];
  int   p0;

  initial begin : main
    vt[0] = '{2'b00,  9,  8, 8'h11, 1'b0, 8'h11, 1'b0};
    vt[1] = '{2'b01,  3,  5, 8'hFE, 1'b1, 8'h00, 1'b1};
    vt[2] = '{2'b00, 15, 15, 8'h1E, 1'b0, 8'h1E, 1'b0};
    vt[3] = '{2'b01, 15, 15, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{2'b01,  0,  1, 8'hFF, 1'b1, 8'h00, 1'b1};
    vt[5] = '{2'b00,  0,  0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[6] = '{2'b01, 10,  3, 8'h07, 1'b0, 8'h07, 1'b0};
    vt[7] = '{2'b11,  7,  9, 8'h00, 1'b0, 8'h00, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; op_a = '0; op_b = '0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(vt[i].m, vt[i].a, vt[i].b);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vt[i].r));
      chk($sformatf("vec%0d_flag", i), 32'(flag), 32'(vt[i].f));
      chk($sformatf("vec%0d_result_s", i), 32'(result_s), 32'(vt[i].rs));
      chk($sformatf("vec%0d_flag_s", i), 32'(flag_s), 32'(vt[i].fs));
      @(posedge clk); #1;
    end

    for (int k = 1; k <= 9; k++) begin
      send(2'b10, 15, 15);
      @(negedge clk);
      if (k < 9) begin
        chk($sformatf("acc%0d_result", k), 32'(result), 32'(30 * k));
        chk($sformatf("acc%0d_flag", k), 32'(flag), 32'd0);
      end else begin
        chk("acc9_result", 32'(result), 32'd14);
        chk("acc9_flag", 32'(flag), 32'd1);
        chk("acc9_result_s", 32'(result_s), 32'd255);
        chk("acc9_flag_s", 32'(flag_s), 32'd1);
        chk("acc9_cnt", 32'(acc_cnt), 32'd9);
      end
      @(posedge clk); #1;
    end
    send(2'b11, 0, 0);
    @(negedge clk);
    chk("clr_result", 32'(result), 32'd0);
    chk("clr_cnt", 32'(acc_cnt), 32'd0);
    chk("clr_cnt_s", 32'(acc_cnt_s), 32'd0);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(2'b00, 1, 2);
    in_valid = 1'b1; mode = 2'b00; op_a = 4'd4; op_b = 4'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_result", 32'(result), 32'd3);
      chk("stall_flag", 32'(flag), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_result", 32'(result), 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("second_valid", 32'(out_valid), 32'd1);
    chk("second_result", 32'(result), 32'd9);
    @(posedge clk); #1;

    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      mode = 2'($urandom_range(0, 1));
      op_a = 4'($urandom_range(0, 15));
      op_b = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (i > 0) chk("stream_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_idle", 32'(out_valid), 32'd0);
    chk("stream_beats", 32'(pops - p0), 32'd16);
    @(posedge clk); #1;

    send(2'b11, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'b10, 15, 15);
    @(negedge clk);
    chk("pre_rst_result", 32'(result), 32'd30);
    chk("pre_rst_cnt", 32'(acc_cnt), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_cnt", 32'(acc_cnt), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b10, 1, 1);
    @(negedge clk);
    chk("post_rst_acc", 32'(result), 32'd2);
    chk("post_rst_acc_s", 32'(result_s), 32'd2);
    chk("post_rst_acc_cnt", 32'(acc_cnt), 32'd1);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
